// File: rtl/huff_encoder_param_if.sv
`default_nettype none
// ============================================================================
//  Module      : huff_encoder_param_if
//  Description : Symbol-in / code-table-out stream bundle for the
//                parametrised Huffman encoder.
//  Revision    : 1.0 - initial release
// ============================================================================
interface huff_encoder_param_if #(
    parameter int SYM_W  = 7,
    parameter int CODE_W = 8
);
    localparam int c_LW = $clog2(CODE_W + 1);

    logic              in_valid;
    logic              in_ready;
    logic [SYM_W-1:0]  in_sym;
    logic              in_last;
    logic              out_valid;
    logic              out_ready;
    logic [SYM_W-1:0]  out_sym;
    logic [CODE_W-1:0] out_code;
    logic [c_LW-1:0]   out_len;
    logic              out_last;
    logic              busy;

    // Producer of symbols / consumer of the code table.
    modport master (
        output in_valid, in_sym, in_last, out_ready,
        input  in_ready, out_valid, out_sym, out_code, out_len, out_last, busy
    );

    // The encoder itself.
    modport slave (
        input  in_valid, in_sym, in_last, out_ready,
        output in_ready, out_valid, out_sym, out_code, out_len, out_last, busy
    );
endinterface
`default_nettype wire

// File: rtl/huff_encoder_param.sv
`default_nettype none
// ============================================================================
//  Module      : huff_encoder_param
//  Description : Collects a block of symbols, counts frequencies, builds a
//                Huffman tree one merge per cycle, assigns canonical codes
//                and streams the (symbol, code, length) table.
//  Revision    : 1.0 - initial release
// ============================================================================
module huff_encoder_param #(
    parameter int SYM_W   = 7,
    parameter int BLK_LEN = 5,
    parameter int CODE_W  = 8
) (
    input  logic                clk,
    input  logic                reset,
    huff_encoder_param_if.slave bus
);
    localparam int c_NODES = 2 * BLK_LEN - 1;
    localparam int c_NID_W = $clog2(c_NODES);
    localparam int c_FW    = $clog2(BLK_LEN + 1);
    localparam int c_LW    = $clog2(CODE_W + 1);

    typedef enum logic [1:0] {
        S_COLLECT = 2'd0,
        S_BUILD   = 2'd1,
        S_CANON   = 2'd2,
        S_EMIT    = 2'd3
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    // Leaves occupy node indices 0..BLK_LEN-1, internal nodes follow.
    logic [SYM_W-1:0]   r_sym   [BLK_LEN];
    logic [c_FW-1:0]    r_freq  [c_NODES];
    logic [c_NODES-1:0] r_act;
    logic [c_NID_W-1:0] r_grp   [BLK_LEN];
    logic [c_LW-1:0]    r_depth [BLK_LEN];
    logic [CODE_W-1:0]  r_code  [BLK_LEN];
    logic [BLK_LEN-1:0] r_asg;
    logic [c_FW-1:0]    r_u;
    logic [c_FW-1:0]    r_cnt;
    logic [c_FW-1:0]    r_mcnt;
    logic [c_FW-1:0]    r_ccnt;
    logic [c_FW-1:0]    r_eidx;
    logic [CODE_W-1:0]  r_pcode;
    logic [c_LW-1:0]    r_pdepth;

    logic               w_accept;
    logic               w_end;
    logic               w_hit;
    logic [BLK_LEN-1:0] w_hit_oh;
    logic [c_FW-1:0]    w_u_nxt;
    logic               w_m1_ok;
    logic               w_m2_ok;
    logic [c_NID_W-1:0] w_m1;
    logic [c_NID_W-1:0] w_m2;
    logic [c_FW-1:0]    w_f1;
    logic [c_FW-1:0]    w_f2;
    logic [c_NID_W-1:0] w_new;
    logic               w_sel_ok;
    logic [BLK_LEN-1:0] w_sel_oh;
    logic [c_LW-1:0]    w_sel_d;
    logic [SYM_W-1:0]   w_sel_s;
    logic [CODE_W-1:0]  w_code_nxt;
    logic [SYM_W-1:0]   w_e_sym;
    logic [CODE_W-1:0]  w_e_code;
    logic [c_LW-1:0]    w_e_len;
    logic               w_e_last;
    logic               w_emit;
    logic               w_done;

    assign w_accept = (r_state == S_COLLECT) && bus.in_valid;
    assign w_end    = bus.in_last || (r_cnt == c_FW'(BLK_LEN - 1));
    assign w_u_nxt  = w_hit ? r_u : r_u + c_FW'(1);
    assign w_new    = c_NID_W'(BLK_LEN) + c_NID_W'(r_mcnt);

    // Look the incoming symbol up among the leaves seen so far.
    always_comb begin
        w_hit    = 1'b0;
        w_hit_oh = '0;
        for (int i = 0; i < BLK_LEN; i++) begin
            if (!w_hit && (c_FW'(i) < r_u) && (r_sym[i] == bus.in_sym)) begin
                w_hit       = 1'b1;
                w_hit_oh[i] = 1'b1;
            end
        end
    end

    // Two smallest active nodes; strict compare in ascending order keeps the lower index on ties.
    always_comb begin
        w_m1_ok = 1'b0;
        w_m1    = '0;
        w_f1    = '0;
        w_m2_ok = 1'b0;
        w_m2    = '0;
        w_f2    = '0;
        for (int n = 0; n < c_NODES; n++) begin
            if (r_act[n] && (!w_m1_ok || (r_freq[n] < w_f1))) begin
                w_m1_ok = 1'b1;
                w_m1    = c_NID_W'(n);
                w_f1    = r_freq[n];
            end
        end
        for (int n = 0; n < c_NODES; n++) begin
            if (r_act[n] && (c_NID_W'(n) != w_m1) && (!w_m2_ok || (r_freq[n] < w_f2))) begin
                w_m2_ok = 1'b1;
                w_m2    = c_NID_W'(n);
                w_f2    = r_freq[n];
            end
        end
    end

    // Next leaf to receive a canonical code: smallest (depth, symbol) not yet assigned.
    always_comb begin
        w_sel_ok = 1'b0;
        w_sel_oh = '0;
        w_sel_d  = '0;
        w_sel_s  = '0;
        for (int l = 0; l < BLK_LEN; l++) begin
            if ((c_FW'(l) < r_u) && !r_asg[l] &&
                (!w_sel_ok || (r_depth[l] < w_sel_d) ||
                 ((r_depth[l] == w_sel_d) && (r_sym[l] < w_sel_s)))) begin
                w_sel_ok    = 1'b1;
                w_sel_oh    = '0;
                w_sel_oh[l] = 1'b1;
                w_sel_d     = r_depth[l];
                w_sel_s     = r_sym[l];
            end
        end
    end

    assign w_code_nxt = (r_ccnt == '0) ? '0
                      : ((r_pcode + CODE_W'(1)) << (w_sel_d - r_pdepth));

    // Table entry currently on offer, in first-appearance order.
    always_comb begin
        w_e_sym  = '0;
        w_e_code = '0;
        w_e_len  = '0;
        for (int l = 0; l < BLK_LEN; l++) begin
            if (c_FW'(l) == r_eidx) begin
                w_e_sym  = r_sym[l];
                w_e_code = r_code[l];
                w_e_len  = r_depth[l];
            end
        end
    end

    assign w_e_last = (r_eidx == r_u - c_FW'(1));
    assign w_emit   = (r_state == S_EMIT);
    assign w_done   = w_emit && bus.out_ready && w_e_last;

    assign bus.in_ready  = (r_state == S_COLLECT);
    assign bus.busy      = (r_state != S_COLLECT);
    assign bus.out_valid = w_emit;
    assign bus.out_sym   = w_emit ? w_e_sym  : '0;
    assign bus.out_code  = w_emit ? w_e_code : '0;
    assign bus.out_len   = w_emit ? w_e_len  : '0;
    assign bus.out_last  = w_emit && w_e_last;

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_COLLECT;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Phase sequencing; a single-leaf block needs no merges and skips BUILD.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_COLLECT: if (w_accept && w_end)
                           w_state_nxt = (w_u_nxt == c_FW'(1)) ? S_CANON : S_BUILD;
            S_BUILD:   if (r_mcnt == r_u - c_FW'(2)) w_state_nxt = S_CANON;
            S_CANON:   if (r_ccnt == r_u - c_FW'(1)) w_state_nxt = S_EMIT;
            S_EMIT:    if (w_done) w_state_nxt = S_COLLECT;
            default:   w_state_nxt = S_COLLECT;
        endcase
    end

    // Tables and counters; cleared on reset and after the last table entry leaves.
    always_ff @(posedge clk) begin
        if (reset || w_done) begin
            for (int n = 0; n < c_NODES; n++) r_freq[n] <= '0;
            for (int l = 0; l < BLK_LEN; l++) begin
                r_sym[l]   <= '0;
                r_grp[l]   <= '0;
                r_depth[l] <= '0;
                r_code[l]  <= '0;
            end
            r_act    <= '0;
            r_asg    <= '0;
            r_u      <= '0;
            r_cnt    <= '0;
            r_mcnt   <= '0;
            r_ccnt   <= '0;
            r_eidx   <= '0;
            r_pcode  <= '0;
            r_pdepth <= '0;
        end else begin
            case (r_state)
                S_COLLECT: begin
                    if (w_accept) begin
                        r_cnt <= w_end ? '0 : r_cnt + c_FW'(1);
                        for (int l = 0; l < BLK_LEN; l++) begin
                            if (w_hit_oh[l]) r_freq[l] <= r_freq[l] + c_FW'(1);
                            if (!w_hit && (c_FW'(l) == r_u)) begin
                                r_sym[l]   <= bus.in_sym;
                                r_freq[l]  <= c_FW'(1);
                                r_act[l]   <= 1'b1;
                                r_grp[l]   <= c_NID_W'(l);
                                r_depth[l] <= '0;
                            end
                        end
                        if (w_end && (w_u_nxt == c_FW'(1))) r_depth[0] <= c_LW'(1);
                        r_u <= w_u_nxt;
                    end
                end
                S_BUILD: begin
                    r_freq[w_new] <= w_f1 + w_f2;
                    r_act[w_m1]   <= 1'b0;
                    r_act[w_m2]   <= 1'b0;
                    r_act[w_new]  <= 1'b1;
                    for (int l = 0; l < BLK_LEN; l++) begin
                        if ((c_FW'(l) < r_u) && ((r_grp[l] == w_m1) || (r_grp[l] == w_m2))) begin
                            r_depth[l] <= r_depth[l] + c_LW'(1);
                            r_grp[l]   <= w_new;
                        end
                    end
                    r_mcnt <= r_mcnt + c_FW'(1);
                end
                S_CANON: begin
                    for (int l = 0; l < BLK_LEN; l++) begin
                        if (w_sel_oh[l]) begin
                            r_code[l] <= w_code_nxt;
                            r_asg[l]  <= 1'b1;
                        end
                    end
                    r_pcode  <= w_code_nxt;
                    r_pdepth <= w_sel_d;
                    r_ccnt   <= r_ccnt + c_FW'(1);
                end
                S_EMIT: begin
                    if (bus.out_ready) r_eidx <= r_eidx + c_FW'(1);
                end
                default: ;
            endcase
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_huff_encoder_param.sv
`default_nettype none
// ============================================================================
//  Module      : tb_huff_encoder_param
//  Description : Directed and randomised blocks against a behavioural
//                Huffman / canonical-code reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_huff_encoder_param;
    localparam int SYM_W   = 7;
    localparam int BLK_LEN = 5;
    localparam int CODE_W  = 8;
    localparam int NODES   = 2 * BLK_LEN - 1;

    typedef logic [SYM_W-1:0] sym_t;
    typedef struct {
        sym_t sym;
        int   code;
        int   len;
    } ent_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   n_checks = 0;
    int   n_errors = 0;
    int   hs_cnt = 0;
    ent_t exp_q[$];
    sym_t blk_q[$];

    huff_encoder_param_if #(.SYM_W(SYM_W), .CODE_W(CODE_W)) bus ();

    huff_encoder_param #(.SYM_W(SYM_W), .BLK_LEN(BLK_LEN), .CODE_W(CODE_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Count every table handshake seen on the output stream.
    always @(posedge clk) begin
        if (bus.out_valid && bus.out_ready) hs_cnt <= hs_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic mk(input int n, input sym_t a, b, c, d, e);
        sym_t t[5];
        t[0] = a; t[1] = b; t[2] = c; t[3] = d; t[4] = e;
        blk_q.delete();
        for (int i = 0; i < n; i++) blk_q.push_back(t[i]);
    endtask

    // Huffman depths via leaf bitmasks, then canonical codes by sorting on (depth, symbol).
    task automatic model(input sym_t s[$]);
        sym_t us[$];
        int   uf[$];
        int   u, a, b, nn, pick, pc, pd;
        int   nf[NODES];
        int   nm[NODES];
        bit   al[NODES];
        int   dep[BLK_LEN];
        int   code[BLK_LEN];
        bit   done[BLK_LEN];
        exp_q.delete();
        foreach (s[i]) begin
            int f;
            f = -1;
            foreach (us[j]) if (us[j] == s[i]) f = j;
            if (f < 0) begin
                us.push_back(s[i]);
                uf.push_back(1);
            end else begin
                uf[f]++;
            end
        end
        u = us.size();
        for (int n = 0; n < NODES; n++) begin nf[n] = 0; nm[n] = 0; al[n] = 0; end
        for (int l = 0; l < BLK_LEN; l++) begin dep[l] = 0; code[l] = 0; done[l] = 0; end
        for (int l = 0; l < u; l++) begin nf[l] = uf[l]; nm[l] = 1 << l; al[l] = 1; end
        if (u == 1) dep[0] = 1;
        for (int k = 0; k < u - 1; k++) begin
            a = -1;
            for (int n = 0; n < NODES; n++) if (al[n] && (a < 0 || nf[n] < nf[a])) a = n;
            al[a] = 0;
            b = -1;
            for (int n = 0; n < NODES; n++) if (al[n] && (b < 0 || nf[n] < nf[b])) b = n;
            al[b] = 0;
            nn = BLK_LEN + k;
            nf[nn] = nf[a] + nf[b];
            nm[nn] = nm[a] | nm[b];
            al[nn] = 1;
            for (int l = 0; l < u; l++) if ((nm[nn] >> l) & 1) dep[l]++;
        end
        pc = 0;
        pd = 0;
        for (int r = 0; r < u; r++) begin
            pick = -1;
            for (int l = 0; l < u; l++)
                if (!done[l] && (pick < 0 || dep[l] < dep[pick] ||
                    (dep[l] == dep[pick] && us[l] < us[pick]))) pick = l;
            done[pick] = 1;
            code[pick] = (r == 0) ? 0 : ((pc + 1) << (dep[pick] - pd));
            pc = code[pick];
            pd = dep[pick];
        end
        for (int l = 0; l < u; l++) exp_q.push_back('{sym: us[l], code: code[l], len: dep[l]});
    endtask

    task automatic check_entry(input ent_t e, input bit last);
        check("out_valid", bus.out_valid, 1);
        check("out_sym", bus.out_sym, e.sym);
        check("out_code", bus.out_code, e.code);
        check("out_len", bus.out_len, e.len);
        check("out_last", bus.out_last, last);
    endtask

    task automatic send(input bit last_on_end, input bit gaps);
        for (int i = 0; i < blk_q.size(); i++) begin
            if (gaps && $urandom_range(0, 3) == 0) begin
                @(negedge clk);
                bus.in_valid = 1'b0;
            end
            @(negedge clk);
            check("in_ready_collect", bus.in_ready, 1);
            bus.in_valid = 1'b1;
            bus.in_sym   = blk_q[i];
            bus.in_last  = last_on_end && (i == blk_q.size() - 1);
            @(posedge clk);
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
    endtask

    task automatic run_block(input bit last_on_end, input int stall, input bit gaps);
        int cyc, hs0, n;
        model(blk_q);
        n = exp_q.size();
        hs0 = hs_cnt;
        bus.out_ready = (stall == 0);
        send(last_on_end, gaps);
        check("in_ready_after_last", bus.in_ready, 0);
        check("busy_after_last", bus.busy, 1);
        cyc = 1;
        while (!bus.out_valid && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        check("latency", cyc, 2 * n);
        for (int e = 0; e < n; e++) begin
            if (e > 0) @(negedge clk);
            if (!bus.out_valid) begin
                check("valid_timeout", 0, 1);
                return;
            end
            for (int s = 0; s < stall; s++) begin
                check_entry(exp_q[e], e == n - 1);
                @(negedge clk);
            end
            bus.out_ready = 1'b1;
            check_entry(exp_q[e], e == n - 1);
            @(posedge clk);
            #1 bus.out_ready = (stall == 0);
        end
        @(negedge clk);
        check("out_valid_after", bus.out_valid, 0);
        check("in_ready_after", bus.in_ready, 1);
        check("busy_after", bus.busy, 0);
        check("handshakes", hs_cnt - hs0, n);
    endtask

    initial begin
        sym_t alph[4];
        int   len;
        bit   lst;
        bus.in_valid  = 1'b0;
        bus.in_sym    = '0;
        bus.in_last   = 1'b0;
        bus.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready", bus.in_ready, 1);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_out_last", bus.out_last, 0);
        check("rst_out_sym", bus.out_sym, 0);
        check("rst_out_code", bus.out_code, 0);
        check("rst_out_len", bus.out_len, 0);
        reset = 1'b0;

        // Directed blocks.
        mk(5, 7'h41, 7'h41, 7'h42, 7'h43, 7'h41); run_block(1, 0, 0);
        mk(5, 7'h01, 7'h02, 7'h03, 7'h04, 7'h05); run_block(1, 0, 0);
        mk(5, 7'h07, 7'h07, 7'h07, 7'h07, 7'h07); run_block(0, 0, 0);
        mk(2, 7'h58, 7'h59, 7'h00, 7'h00, 7'h00); run_block(1, 0, 0);
        mk(5, 7'h41, 7'h41, 7'h42, 7'h43, 7'h41); run_block(1, 4, 0);

        // Reset during BUILD discards the block entirely.
        mk(5, 7'h01, 7'h02, 7'h03, 7'h04, 7'h05);
        bus.out_ready = 1'b1;
        send(1, 0);
        check("mid_busy", bus.busy, 1);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("mid_rst_in_ready", bus.in_ready, 1);
        check("mid_rst_out_valid", bus.out_valid, 0);
        check("mid_rst_busy", bus.busy, 0);
        begin
            int h;
            h = hs_cnt;
            repeat (12) @(negedge clk);
            check("mid_rst_no_emit", hs_cnt - h, 0);
        end
        mk(3, 7'h41, 7'h41, 7'h42, 7'h00, 7'h00); run_block(1, 0, 0);

        // Randomised blocks over small alphabets to force repeats and ties.
        for (int t = 0; t < 40; t++) begin
            for (int k = 0; k < 4; k++) alph[k] = sym_t'($urandom_range(0, 127));
            len = $urandom_range(1, BLK_LEN);
            blk_q.delete();
            for (int i = 0; i < len; i++) blk_q.push_back(alph[$urandom_range(0, 3)]);
            lst = (len < BLK_LEN) ? 1'b1 : 1'(($urandom_range(0, 1)));
            run_block(lst, $urandom_range(0, 2), 1);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule
`default_nettype wire

// File: doc/huff_encoder_param.md
Name: huff_encoder_param

Overview:
- Parametrised successor to the fixed 5-symbol Huffman encoder.
- Accepts a variable-length block of symbols over a valid/ready stream and counts symbol frequencies as they arrive.
- Builds the Huffman tree with one merge per cycle, then assigns canonical codes.
- Streams the code table (symbol, code, length) out over a valid/ready interface. Feeds the downstream bit packer.

Parameters:
- SYM_W, 7: symbol width in bits.
- BLK_LEN, 5: maximum symbols per block; also the maximum number of unique symbols. Must be >= 2.
- CODE_W, 8: width of out_code. Must be >= BLK_LEN-1, the maximum possible code length.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  input symbol valid.
- in_ready  out  1  encoder can accept a symbol.
- in_sym  in  SYM_W  input symbol.
- in_last  in  1  final symbol of the block.
- out_valid  out  1  table entry valid.
- out_ready  in  1  downstream accepts the entry.
- out_sym  out  SYM_W  symbol of this entry.
- out_code  out  CODE_W  code, right-aligned; bits at and above out_len are 0.
- out_len  out  clog2(CODE_W+1)  code length, 1..BLK_LEN-1.
- out_last  out  1  last entry of the table.
- busy  out  1  high in every state except COLLECT.

Behaviour:
- Reset, applied whenever reset=1 at a clock edge in any state:
  - state=COLLECT; all frequency, depth and code tables cleared; unique count U=0.
  - in_ready=1, out_valid=0, out_last=0, out_sym/out_code/out_len=0, busy=0.
  - Reset mid-operation discards the partial block and any unsent table; no entry is emitted afterwards.
- States: COLLECT -> BUILD -> CANON -> EMIT -> COLLECT.
- COLLECT (in_ready=1):
  - Each beat where in_valid&in_ready is accepted.
  - If in_sym matches an existing leaf, that leaf's freq increments.
  - Otherwise a new leaf is created at index U with freq=1 and U increments.
  - Leaf order is first-appearance order.
  - The block ends on an accepted beat with in_last=1, or on the BLK_LEN-th accepted beat, whichever comes first. in_last is ignored beyond that.
  - Next state is BUILD.
- BUILD (in_ready=0):
  - Exactly U-1 cycles, one merge per cycle; 0 cycles if U==1.
  - Active set = unmerged leaves plus internal nodes. Internal node k (k=0..) has index BLK_LEN+k.
  - Each merge picks the minimum-freq active node, then the minimum-freq remaining active node. Ties go to the lower index.
  - The new node's freq is the sum of the two. Every leaf under either child has depth incremented by 1, tracked through a per-leaf group id.
  - Freq width is clog2(BLK_LEN+1); sums never exceed BLK_LEN.
  - If U==1, the single leaf is forced to depth 1.
- CANON:
  - Exactly U cycles; each cycle assigns one leaf.
  - Pick the unassigned leaf with the smallest (depth, symbol value).
  - First leaf: code=0.
  - Subsequent leaf: code = (prev_code+1) << (depth - prev_depth).
- EMIT:
  - One entry per leaf, in first-appearance order.
  - out_valid is held high. The entry is held stable while out_ready=0.
  - Advance on out_valid&out_ready.
  - out_last=1 on entry U-1.
  - After the last handshake: next cycle out_valid=0, state=COLLECT, in_ready=1.
- No overlap between blocks: in_ready=0 from the cycle after the final input beat until EMIT completes.
- Latency: last input beat to first out_valid = (U-1) + U + 1 cycles.

Test Plan:
- Block 0x41,0x41,0x42,0x43,0x41, in_last on the 5th beat, out_ready=1. Expect 3 entries: 0x41 code 0b0 len1; 0x42 code 0b10 len2; 0x43 code 0b11 len2 with out_last. First out_valid arrives 6 cycles after the last beat.
- Block 1,2,3,4,5, all distinct. Expect:
  - sym1 code 110 len3
  - sym2 code 111 len3
  - sym3 code 00 len2
  - sym4 code 01 len2
  - sym5 code 10 len2, with out_last
- Block 0x07 x5 with no in_last: the 5th beat ends the block. Expect a single entry 0x07 code 0 len1 with out_last.
- Short block 0x58,0x59 with in_last on the 2nd beat. Expect 0x58 code 0 len1, then 0x59 code 1 len1. in_ready returns to 1 after the handshake.
- Backpressure: same as the first scenario, with out_ready=0 for 4 cycles at each entry. Required response:
  - outputs hold stable;
  - no entry is skipped or duplicated;
  - exactly 3 handshakes.
- Reset asserted for 1 cycle during BUILD of the second scenario. Required response:
  - next cycle in_ready=1, out_valid=0, busy=0;
  - a following block 0x41,0x41,0x42 gives 0x41 len1 code 0 and 0x42 len1 code 1 only.
